mem_arb: RTL and testbench
==========================

MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 The block SHALL provide parameter TIMEOUT, default 15, as the maximum cycles in BUSY without mem_done before abort (legal range 2-15).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 The block SHALL have ports i_req (input, 1, fetch read request) and i_addr (input, 16, fetch address).
REQ-005 The block SHALL have ports d_req (input, 1, data request), d_wr (input, 1, 1=write), d_addr (input, 16) and d_wdata (input, 16).
REQ-006 The block SHALL have ports i_done and d_done (output, 1 each, one-cycle completion pulse per requester).
REQ-007 The block SHALL have ports i_stall and d_stall (output, 1 each, requester must hold its request).
REQ-008 The block SHALL have port rdata (output, 16, registered read data valid with i_done/d_done).
REQ-009 The block SHALL have ports mem_en, mem_wr (output, 1), mem_addr and mem_wdata (output, 16): backend command.
REQ-010 The block SHALL have ports mem_done (input, 1, backend completion) and mem_rdata (input, 16, valid with mem_done).
REQ-011 The block SHALL have port err (output, 1, sticky timeout flag).

Function
REQ-012 The block SHALL implement states IDLE, BUSY_I and BUSY_D in one shared memory port.
REQ-013 In IDLE, with any request, the block SHALL grant one requester and enter BUSY_I/BUSY_D next cycle, latching addr/wr/wdata of the winner at the grant edge.
REQ-014 Arbitration SHALL be fixed priority to d_req, except that when skip_cnt==2 and i_req=1, the fetch SHALL win.
REQ-015 skip_cnt (2-bit, saturating at 2) SHALL increment when d wins while i_req=1, and clear when i wins or i_req=0 in IDLE.
REQ-016 mem_en SHALL be 1 for exactly the first cycle of each BUSY state; mem_addr/mem_wr/mem_wdata SHALL hold the latched values throughout BUSY, with mem_wr=0 in BUSY_I.
REQ-017 mem_done SHALL be honoured only in BUSY states, including the same cycle as mem_en; in IDLE it SHALL be ignored.
REQ-018 On mem_done in BUSY_x, the block SHALL return to IDLE next cycle, pulse x_done for that one cycle, and register rdata<=mem_rdata (writes: rdata<=mem_rdata, don't-care to requester).
REQ-019 Latency SHALL be minimum 3 cycles from request at IDLE to done pulse (grant edge, BUSY with mem_done, done cycle); no new grant occurs in the done cycle's preceding BUSY cycle.
REQ-020 x_stall SHALL equal x_req & ~x_done, combinationally.
REQ-021 A 4-bit cycle counter SHALL clear on BUSY entry and increment each BUSY cycle without mem_done; reaching TIMEOUT SHALL set err, return to IDLE, pulse x_done with rdata<=0.
REQ-022 err SHALL remain 1 until rst; arbitration continues normally after a timeout.
REQ-023 Requester dropping x_req while granted SHALL NOT abort the transaction; done pulse still issued.
REQ-024 Simultaneous i_req and d_req in IDLE with skip_cnt<2 SHALL grant d.

Reset
REQ-025 While rst=1 at a clock edge: state<=IDLE, skip_cnt<=0, counter<=0, err<=0, rdata<=0, i_done=d_done=mem_en=mem_wr=0, mem_addr=mem_wdata=0.
REQ-026 rst asserted mid-BUSY SHALL drop the transaction; a later mem_done SHALL produce no done pulse.

Verification
REQ-027 Single fetch: i_req=1, i_addr=0x0040, mem_done 2 cycles after mem_en with mem_rdata=0xBEEF -> one mem_en, mem_wr=0, i_done pulse, rdata=0xBEEF, i_stall low in done cycle.
REQ-028 Write: d_req=1, d_wr=1, d_addr=0x1234, d_wdata=0x5A5A -> mem_en once with mem_wr=1 and those values held until mem_done; d_done pulses.
REQ-029 Contention: i_req and d_req held high continuously -> grant order D, D, I, D, D, I; skip_cnt never exceeds 2.
REQ-030 Timeout: TIMEOUT=15, d_req granted, mem_done never asserted -> d_done pulses after 15 BUSY cycles, rdata=0, err=1 and stays 1 through later successful transactions.
REQ-031 Reset mid-op: rst in 2nd BUSY cycle, mem_done one cycle later -> no done pulses, state IDLE, all outputs 0.
REQ-032 Back-to-back: d_req held with mem_done same cycle as mem_en -> d_done every 3 cycles, mem_en never asserted two consecutive cycles.

Source files
------------

// File: rtl/mem_arb.sv
// mem_arb: two-requester arbiter sharing one memory port with anti-starvation and timeout
module mem_arb #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        i_done,
  output logic        d_done,
  output logic        i_stall,
  output logic        d_stall,
  output logic [15:0] rdata,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_done,
  input  logic [15:0] mem_rdata,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
  state_t     r_state;
  logic [1:0] r_skip;
  logic [3:0] r_cnt;
  logic       w_open, w_gnt_i, w_gnt_d, w_to;
  assign w_open  = (r_state == IDLE) & ~i_done & ~d_done;
  assign w_gnt_i = w_open & i_req & (~d_req | (r_skip == 2'd2));
  assign w_gnt_d = w_open & d_req & ~w_gnt_i;
  assign w_to    = (r_state != IDLE) & ~mem_done & (r_cnt == 4'(TIMEOUT - 1));
  assign i_stall = i_req & ~i_done;
  assign d_stall = d_req & ~d_done;
  // arbitration, transaction tracking and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_skip    <= '0;
      r_cnt     <= '0;
      err       <= 1'b0;
      rdata     <= '0;
      i_done    <= 1'b0;
      d_done    <= 1'b0;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      mem_en <= 1'b0;
      if (r_state == IDLE) begin
        r_skip <= (!i_req || w_gnt_i) ? 2'd0 : (w_gnt_d && r_skip != 2'd2) ? r_skip + 2'd1 : r_skip;
        if (w_gnt_i || w_gnt_d) begin
          r_state  <= w_gnt_i ? BUSY_I : BUSY_D;
          r_cnt    <= '0;
          mem_en   <= 1'b1;
          mem_addr <= w_gnt_i ? i_addr : d_addr;
          mem_wr   <= w_gnt_d & d_wr;
          if (w_gnt_d) mem_wdata <= d_wdata;
        end
      end else if (mem_done || w_to) begin
        r_state <= IDLE;
        i_done  <= r_state == BUSY_I;
        d_done  <= r_state == BUSY_D;
        rdata   <= mem_done ? mem_rdata : 16'd0;
        err     <= err | w_to;
      end else begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed checks of mem_arb grant order, latency, timeout and reset
module tb_mem_arb;
  logic        clk = 0, rst = 1;
  logic        i_req = 0, d_req = 0, d_wr = 0, mem_done = 0;
  logic [15:0] i_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
  logic        i_done, d_done, i_stall, d_stall, mem_en, mem_wr, err;
  logic [15:0] rdata, mem_addr, mem_wdata;
  int n_chk = 0, n_err = 0;
  mem_arb #(.TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .i_req(i_req), .i_addr(i_addr), .d_req(d_req), .d_wr(d_wr),
    .d_addr(d_addr), .d_wdata(d_wdata), .i_done(i_done), .d_done(d_done),
    .i_stall(i_stall), .d_stall(d_stall), .rdata(rdata), .mem_en(mem_en), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .err(err)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    logic [15:0] order [6];
    logic [15:0] want [6];
    int ng, n, consec, last, nd;
    logic prev_en;
    want = '{16'h2222, 16'h2222, 16'h1111, 16'h2222, 16'h2222, 16'h1111};
    tick(); tick();
    chk("rst_en", mem_en, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_err", err, 0);
    chk("rst_done", {i_done, d_done}, 0);
    rst = 0;
    i_req = 1; i_addr = 16'h0040;
    tick();
    chk("f_en", mem_en, 1);
    chk("f_wr", mem_wr, 0);
    chk("f_addr", mem_addr, 16'h0040);
    chk("f_stall", i_stall, 1);
    tick();
    chk("f_en2", mem_en, 0);
    tick();
    mem_done = 1; mem_rdata = 16'hBEEF;
    tick();
    mem_done = 0;
    chk("f_done", i_done, 1);
    chk("f_rdata", rdata, 16'hBEEF);
    chk("f_stall_done", i_stall, 0);
    chk("f_en_done", mem_en, 0);
    i_req = 0;
    tick();
    chk("f_done_pulse", i_done, 0);
    d_req = 1; d_wr = 1; d_addr = 16'h1234; d_wdata = 16'h5A5A;
    tick();
    chk("w_en", mem_en, 1);
    chk("w_cmd", {mem_wr, mem_addr, mem_wdata}, {1'b1, 16'h1234, 16'h5A5A});
    tick();
    chk("w_hold", {mem_en, mem_wr, mem_addr, mem_wdata}, {1'b0, 1'b1, 16'h1234, 16'h5A5A});
    mem_done = 1;
    tick();
    mem_done = 0; d_req = 0; d_wr = 0;
    chk("w_done", {d_done, i_done}, 2'b10);
    tick();
    i_addr = 16'h1111; d_addr = 16'h2222; mem_rdata = 16'hC0DE;
    i_req = 1; d_req = 1;
    ng = 0; n = 0; consec = 0; prev_en = 0;
    while (ng < 6 && n < 60) begin
      tick(); n++;
      if (prev_en && mem_en) consec++;
      prev_en = mem_en;
      mem_done = mem_en;
      if (mem_en) begin order[ng] = mem_addr; ng++; end
    end
    chk("c_grants", ng, 6);
    for (int k = 0; k < 6; k++) chk($sformatf("c_order%0d", k), order[k], want[k]);
    i_req = 0; d_req = 0;
    tick();
    mem_done = 0;
    tick();
    chk("c_consec_en", consec, 0);
    d_req = 1; mem_done = 1; mem_rdata = 16'h0F0F;
    last = -1; nd = 0; consec = 0; prev_en = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (prev_en && mem_en) consec++;
      prev_en = mem_en;
      if (d_done) begin
        if (last >= 0) chk("b_period", c - last, 3);
        last = c; nd++;
      end
    end
    chk("b_count", nd >= 5, 1);
    chk("b_consec_en", consec, 0);
    d_req = 0; mem_done = 0;
    tick(); tick(); tick();
    d_req = 1; mem_rdata = 16'hAAAA;
    tick();
    chk("t_en", mem_en, 1);
    n = 0;
    while (!d_done && n < 40) begin tick(); n++; end
    d_req = 0;
    chk("t_cycles", n, 15);
    chk("t_rdata", rdata, 0);
    chk("t_err", err, 1);
    tick();
    i_req = 1; i_addr = 16'h0005; mem_rdata = 16'h1357;
    tick();
    mem_done = 1;
    tick();
    i_req = 0; mem_done = 0;
    chk("t2_done", i_done, 1);
    chk("t2_rdata", rdata, 16'h1357);
    chk("t2_err", err, 1);
    tick();
    d_req = 1; d_addr = 16'h0777;
    tick(); tick();
    rst = 1; d_req = 0;
    tick();
    rst = 0; mem_done = 1;
    tick();
    chk("r_done", {i_done, d_done}, 0);
    chk("r_outs", {mem_en, mem_wr, mem_addr, mem_wdata, rdata, err}, 0);
    mem_done = 0;
    tick();
    chk("r_done2", {i_done, d_done, mem_en}, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
